// File: rtl/bk_sub16_pipe_if.sv
// Valid/ready stream bundle for bk_sub16_pipe: operand side plus result side.
// The slave modport is the subtractor; the master modport is whoever feeds and drains it.
interface bk_sub16_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero
  );
endinterface

// File: rtl/bk_sub16_pipe.sv
// Pipelined 16-bit subtractor (a - b - bin) on a Brent-Kung prefix carry tree.
// Define BK_SUB16_FLAGS_EN to compute the ovf/zero flags; otherwise both read 0.
module bk_sub16_pipe #(
  parameter int LATENCY = 3
) (
  input logic         clk,
  input logic         rst_n,
  bk_sub16_pipe_if.slave bus
);

  typedef struct packed {
    logic [15:0] p;
    logic [15:0] g;
    logic        cin;
  } pre_t;

  // p keeps the per-bit propagate for the sum; tp/tg hold the tree after up-sweep.
  typedef struct packed {
    logic [15:0] p;
    logic [15:0] tp;
    logic [15:0] tg;
    logic        cin;
  } mid_t;

  // Carry-in is folded into bit 0's generate so the tree yields C[i+1] in tg[i].
  function automatic mid_t up_sweep(input pre_t s);
    mid_t m;
    // NOTE: blocking assignments are right here: each tree level reads the level before it.
    m.p     = s.p;
    m.cin   = s.cin;
    m.tp    = s.p;
    m.tg    = s.g;
    m.tg[0] = s.g[0] | (s.p[0] & s.cin);
    for (int lvl = 0; lvl < 4; lvl++) begin
      for (int i = (2 << lvl) - 1; i < 16; i += (2 << lvl)) begin
        m.tg[i] = m.tg[i] | (m.tp[i] & m.tg[i - (1 << lvl)]);
        m.tp[i] = m.tp[i] & m.tp[i - (1 << lvl)];
      end
    end
    return m;
  endfunction

  // Returns {bout, diff}.
  function automatic logic [16:0] down_sweep(input mid_t m);
    logic [15:0] tg;
    logic [16:0] c;
    tg = m.tg;
    for (int lvl = 2; lvl >= 0; lvl--) begin
      for (int i = (3 << lvl) - 1; i < 16; i += (2 << lvl)) begin
        tg[i] = tg[i] | (m.tp[i] & tg[i - (1 << lvl)]);
      end
    end
    c = {tg, m.cin};
    return {~c[16], m.p ^ c[15:0]};
  endfunction

  pre_t        s1_d;
  pre_t        s1_q;
  mid_t        mid_in;
  logic        v1;
  logic        v3;
  logic        load1;
  logic        load3;
  logic        load_mid;
  logic        mid_valid;
  logic [16:0] res;
  logic [15:0] diff_q;
  logic        bout_q;

  assign s1_d = '{p: bus.a ^ ~bus.b, g: bus.a & ~bus.b, cin: ~bus.bin};

  assign load3         = ~v3 | bus.out_ready;
  assign load1         = ~v1 | load_mid;
  assign bus.in_ready  = load1;
  assign bus.out_valid = v3;

`ifdef BK_SUB16_FLAGS_EN
  logic [1:0] sgn1;
  logic [1:0] sgn_mid;
  logic       ovf_q;
  logic       zero_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v1 <= 1'b0;
    else if (load1) v1 <= bus.in_valid;
  end

  // NOTE: datapath registers behind a valid bit need no reset; only valids and visible outputs do.
  always_ff @(posedge clk) begin
    if (load1 && bus.in_valid) begin
      s1_q <= s1_d;
`ifdef BK_SUB16_FLAGS_EN
      sgn1 <= {bus.a[15], bus.b[15]};
`endif
    end
  end

  generate
    if (LATENCY == 3) begin : g_lat3
      logic v2;
      mid_t s2_q;
`ifdef BK_SUB16_FLAGS_EN
      logic [1:0] sgn2;
      assign sgn_mid = sgn2;
`endif
      assign load_mid  = ~v2 | load3;
      assign mid_in    = s2_q;
      assign mid_valid = v2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) v2 <= 1'b0;
        else if (load_mid) v2 <= v1;
      end

      always_ff @(posedge clk) begin
        if (load_mid && v1) begin
          s2_q <= up_sweep(s1_q);
`ifdef BK_SUB16_FLAGS_EN
          sgn2 <= sgn1;
`endif
        end
      end
    end else if (LATENCY == 2) begin : g_lat2
      // Whole prefix tree sits between S1 and the output stage.
      assign load_mid  = load3;
      assign mid_in    = up_sweep(s1_q);
      assign mid_valid = v1;
`ifdef BK_SUB16_FLAGS_EN
      assign sgn_mid   = sgn1;
`endif
    end else begin : g_bad_latency
      $error("bk_sub16_pipe: LATENCY must be 2 or 3");
    end
  endgenerate

  assign res = down_sweep(mid_in);

  // Output stage resets so the result bus reads 0 and holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3     <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
`ifdef BK_SUB16_FLAGS_EN
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
`endif
    end else if (load3) begin
      v3 <= mid_valid;
      if (mid_valid) begin
        diff_q <= res[15:0];
        bout_q <= res[16];
`ifdef BK_SUB16_FLAGS_EN
        ovf_q  <= (sgn_mid[1] != sgn_mid[0]) & (res[15] != sgn_mid[1]);
        zero_q <= (res[15:0] == 16'h0000);
`endif
      end
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef BK_SUB16_FLAGS_EN
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
`else
  assign bus.ovf  = 1'b0;
  assign bus.zero = 1'b0;
`endif

endmodule

// File: tb/tb_bk_sub16_pipe.sv
// Self-checking bench for bk_sub16_pipe: directed vectors on a LATENCY=3 instance,
// then a scoreboarded random stream on LATENCY=3 and LATENCY=2 instances together.
module tb_bk_sub16_pipe;

`ifdef BK_SUB16_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif
  localparam int NOPS = 10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bk_sub16_pipe_if bus3();
  bk_sub16_pipe_if bus2();

  bk_sub16_pipe #(.LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));
  bk_sub16_pipe #(.LATENCY(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 17-bit subtraction; bit 16 is the borrow.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] t;
    logic        o;
    logic        z;
    t = {1'b0, a} - {1'b0, b} - {16'h0000, bin};
    o = FLAGS & (a[15] != b[15]) & (t[15] != a[15]);
    z = FLAGS & (t[15:0] == 16'h0000);
    return {o, z, t};
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // One operation through the LATENCY=3 instance with out_ready high.
  task automatic op3(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bin,
                     input logic [15:0] ed, input logic eb, input logic eo, input logic ez);
    bus3.a = a; bus3.b = b; bus3.bin = bin;
    bus3.in_valid = 1'b1; bus3.out_ready = 1'b1;
    #1 check({tag, "_rdy"}, 32'(bus3.in_ready), 32'd1);
    cyc();
    bus3.in_valid = 1'b0;
    check({tag, "_lat1"}, 32'(bus3.out_valid), 32'd0);
    cyc();
    check({tag, "_lat2"}, 32'(bus3.out_valid), 32'd0);
    cyc();
    check({tag, "_vld"},  32'(bus3.out_valid), 32'd1);
    check({tag, "_diff"}, 32'(bus3.diff), 32'(ed));
    check({tag, "_bout"}, 32'(bus3.bout), 32'(eb));
    check({tag, "_ovf"},  32'(bus3.ovf),  32'(FLAGS & eo));
    check({tag, "_zero"}, 32'(bus3.zero), 32'(FLAGS & ez));
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [18:0] q3[$];
    logic [18:0] q2[$];
    logic [18:0] exp;
    int nxt, got, last, stale, sent3, sent2;

    bus3.in_valid = 1'b0; bus3.a = '0; bus3.b = '0; bus3.bin = 1'b0; bus3.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.bin = 1'b0; bus2.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_vld",  32'(bus3.out_valid), 32'd0);
    check("rst_diff", 32'(bus3.diff), 32'd0);
    check("rst_bout", 32'(bus3.bout), 32'd0);
    check("rst_flag", {30'd0, bus3.ovf, bus3.zero}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    cyc();
    check("rst_rdy", 32'(bus3.in_ready), 32'd1);

    // Directed vectors: tag, a, b, bin, diff, bout, ovf, zero
    op3("basic",  16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    op3("wrap",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    op3("ovfneg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    op3("zero",   16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    op3("minmax", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    op3("maxmin", 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    op3("eqbin",  16'h4321, 16'h4321, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    op3("ovfpos", 16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0);

    // Backpressure: fill with out_ready low, then release and stream
    bus3.out_ready = 1'b0; bus3.b = '0; bus3.bin = 1'b0;
    nxt = 1;
    for (int c = 0; c < 8; c++) begin
      bus3.in_valid = (nxt <= 6);
      bus3.a = 16'(nxt);
      #1;
      if (c >= 3) check("bp_hold", 32'(bus3.diff), 32'd1);
      if (bus3.in_valid && bus3.in_ready) nxt++;
      cyc();
    end
    check("bp_accepts", 32'(nxt - 1), 32'd3);
    check("bp_full",    32'(bus3.in_ready), 32'd0);
    check("bp_vld",     32'(bus3.out_valid), 32'd1);
    bus3.out_ready = 1'b1;
    #1 check("bp_release_rdy", 32'(bus3.in_ready), 32'd1);
    got = 1; last = -1;
    for (int c = 0; c < 20 && got <= 6; c++) begin
      bus3.in_valid = (nxt <= 6);
      bus3.a = 16'(nxt);
      #1;
      if (bus3.out_valid && bus3.out_ready) begin
        check("bp_order", 32'(bus3.diff), 32'(got));
        if (last >= 0) check("bp_gap", 32'(c - last), 32'd1);
        last = c;
        got++;
      end
      if (bus3.in_valid && bus3.in_ready) nxt++;
      cyc();
    end
    check("bp_count", 32'(got), 32'd7);
    bus3.in_valid = 1'b0;
    cyc();

    // Reset with two operations in flight
    bus3.out_ready = 1'b0;
    bus3.in_valid = 1'b1; bus3.a = 16'h0100; bus3.b = 16'h0001; bus3.bin = 1'b0;
    cyc();
    bus3.a = 16'h0200; bus3.b = 16'h0002;
    cyc();
    bus3.in_valid = 1'b0;
    cyc();
    check("mid_vld",  32'(bus3.out_valid), 32'd1);
    check("mid_diff", 32'(bus3.diff), 32'h00FF);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_vld",  32'(bus3.out_valid), 32'd0);
    check("mid_rst_diff", 32'(bus3.diff), 32'd0);
    check("mid_rst_bout", 32'(bus3.bout), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    bus3.out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (bus3.out_valid) stale++;
    end
    check("post_rst_stale", 32'(stale), 32'd0);
    op3("post_rst", 16'h0010, 16'h0003, 1'b0, 16'h000D, 1'b0, 1'b0, 1'b0);

    // Random stream on both latencies with random backpressure
    sent3 = 0; sent2 = 0;
    for (int c = 0; c < 60000 && !(sent3 == NOPS && sent2 == NOPS && q3.size() == 0 && q2.size() == 0); c++) begin
      bus3.in_valid  = (sent3 < NOPS) && ($urandom_range(0, 3) != 0);
      bus3.a = rnd16(); bus3.b = rnd16(); bus3.bin = 1'($urandom);
      bus3.out_ready = ($urandom_range(0, 2) != 0);
      bus2.in_valid  = (sent2 < NOPS) && ($urandom_range(0, 3) != 0);
      bus2.a = rnd16(); bus2.b = rnd16(); bus2.bin = 1'($urandom);
      bus2.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (bus3.out_valid && bus3.out_ready) begin
        if (q3.size() == 0) check("r3_extra", 32'd1, 32'd0);
        else begin
          exp = q3.pop_front();
          check("r3_res", {13'd0, bus3.ovf, bus3.zero, bus3.bout, bus3.diff}, 32'(exp));
        end
      end
      if (bus3.in_valid && bus3.in_ready) begin
        q3.push_back(model(bus3.a, bus3.b, bus3.bin));
        sent3++;
      end
      if (bus2.out_valid && bus2.out_ready) begin
        if (q2.size() == 0) check("r2_extra", 32'd1, 32'd0);
        else begin
          exp = q2.pop_front();
          check("r2_res", {13'd0, bus2.ovf, bus2.zero, bus2.bout, bus2.diff}, 32'(exp));
        end
      end
      if (bus2.in_valid && bus2.in_ready) begin
        q2.push_back(model(bus2.a, bus2.b, bus2.bin));
        sent2++;
      end
      cyc();
    end
    check("r3_sent",  32'(sent3), NOPS);
    check("r2_sent",  32'(sent2), NOPS);
    check("r3_drain", 32'(q3.size()), 32'd0);
    check("r2_drain", 32'(q2.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
